// File: rtl/proc_datapath_core_if.sv
// Datapath bus bundle: register values, bus selects, ALU and PC controls in;
// bus value, ALU result and PC out.
interface proc_datapath_core_if #(
    parameter int unsigned WIDTH = 16
);
    // General registers and special operands presented to the bus mux
    logic [WIDTH-1:0] R0;
    logic [WIDTH-1:0] R1;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] R3;
    logic [WIDTH-1:0] R4;
    logic [WIDTH-1:0] R5;
    logic [WIDTH-1:0] R6;
    logic [WIDTH-1:0] DIN;
    logic [WIDTH-1:0] G;
    logic [WIDTH-1:0] A;

    // Bus selects
    logic             din_out;
    logic [7:0]       reg_out;
    logic             g_out;

    // ALU / PC controls
    logic [2:0]       alu_op;
    logic             pc_en;
    logic             pc_load;
    logic             pc_incr;

    // Datapath results
    logic [WIDTH-1:0] BusWires;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] pc;

    // Control side: drives operands and controls, observes results
    modport master (
        output R0, R1, R2, R3, R4, R5, R6, DIN, G, A,
        output din_out, reg_out, g_out,
        output alu_op, pc_en, pc_load, pc_incr,
        input  BusWires, alu_result, pc
    );

    // Datapath side
    modport slave (
        input  R0, R1, R2, R3, R4, R5, R6, DIN, G, A,
        input  din_out, reg_out, g_out,
        input  alu_op, pc_en, pc_load, pc_incr,
        output BusWires, alu_result, pc
    );
endinterface

// File: rtl/proc_datapath_core.sv
// Processor datapath core: priority bus mux, ALU fed by A and the bus,
// and the program counter (R7) which can be loaded from or driven onto the bus.
module proc_datapath_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    proc_datapath_core_if.slave bus
);
    localparam int unsigned SHAMT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned NREG    = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;

    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_regs [NREG];
    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_alu;
    logic [SHAMT_W-1:0] w_shamt;

    // Register file view indexed by reg_out bit; slot 7 is the PC
    always_comb begin
        w_regs[0] = bus.R0;
        w_regs[1] = bus.R1;
        w_regs[2] = bus.R2;
        w_regs[3] = bus.R3;
        w_regs[4] = bus.R4;
        w_regs[5] = bus.R5;
        w_regs[6] = bus.R6;
        w_regs[7] = r_pc;
    end

    // Bus mux: DIN beats any register, lowest register index beats higher, G is last
    always_comb begin
        w_bus = '0;
        if (bus.g_out) begin
            w_bus = bus.G;
        end
        // Walk downwards so the lowest set bit is the final assignment
        for (int i = NREG - 1; i >= 0; i--) begin
            if (bus.reg_out[i]) begin
                w_bus = w_regs[i];
            end
        end
        if (bus.din_out) begin
            w_bus = bus.DIN;
        end
    end

    assign w_shamt = w_bus[SHAMT_W-1:0];

    // ALU with B taken straight from the bus; unused opcodes give zero
    always_comb begin
        w_alu = '0;
        case (bus.alu_op)
            OP_ADD:  w_alu = bus.A + w_bus;
            OP_SUB:  w_alu = bus.A - w_bus;
            OP_OR:   w_alu = bus.A | w_bus;
            OP_SLT:  w_alu = WIDTH'(bus.A < w_bus);
            OP_SLL:  w_alu = bus.A << w_shamt;
            OP_SRL:  w_alu = bus.A >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    // PC: reset, then enable gate, then load over increment
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc <= '0;
        end else if (bus.pc_en) begin
            if (bus.pc_load) begin
                r_pc <= w_bus;
            end else if (bus.pc_incr) begin
                r_pc <= r_pc + WIDTH'(1);
            end
        end
    end

    assign bus.BusWires   = w_bus;
    assign bus.alu_result = w_alu;
    assign bus.pc         = r_pc;

endmodule

// File: tb/tb_proc_datapath_core.sv
// Directed bench for proc_datapath_core: stimulus pushes expectations into a
// queue, an independent monitor pops and compares one entry per cycle.
module tb_proc_datapath_core;
    localparam int unsigned WIDTH = 16;

    logic Clock;
    logic Reset;

    proc_datapath_core_if #(.WIDTH(WIDTH)) bus ();

    proc_datapath_core #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string            name;
        bit               cb;
        logic [WIDTH-1:0] eb;
        bit               ca;
        logic [WIDTH-1:0] ea;
        bit               cp;
        logic [WIDTH-1:0] ep;
    } exp_t;

    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam bit [2:0] M_B   = 3'b100;
    localparam bit [2:0] M_A   = 3'b010;
    localparam bit [2:0] M_P   = 3'b001;
    localparam bit [2:0] M_BA  = 3'b110;
    localparam bit [2:0] M_BAP = 3'b111;

    // Monitor: outputs are sampled mid-cycle, after inputs have settled
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cb) begin
                n_tests++;
                if (bus.BusWires !== e.eb) begin
                    n_fail++;
                    $display("FAIL %s BusWires: got %h want %h", e.name, bus.BusWires, e.eb);
                end
            end
            if (e.ca) begin
                n_tests++;
                if (bus.alu_result !== e.ea) begin
                    n_fail++;
                    $display("FAIL %s alu_result: got %h want %h", e.name, bus.alu_result, e.ea);
                end
            end
            if (e.cp) begin
                n_tests++;
                if (bus.pc !== e.ep) begin
                    n_fail++;
                    $display("FAIL %s pc: got %h want %h", e.name, bus.pc, e.ep);
                end
            end
        end
    end

    task automatic clr();
        bus.R0 = 16'h0; bus.R1 = 16'h0; bus.R2 = 16'h0; bus.R3 = 16'h0;
        bus.R4 = 16'h0; bus.R5 = 16'h0; bus.R6 = 16'h0;
        bus.DIN = 16'h0; bus.G = 16'h0; bus.A = 16'h0;
        bus.din_out = 1'b0; bus.reg_out = 8'h00; bus.g_out = 1'b0;
        bus.alu_op = 3'b000; bus.pc_en = 1'b0; bus.pc_load = 1'b0; bus.pc_incr = 1'b0;
    endtask

    // Queue the expectation for the current input set, then advance one cycle
    task automatic cyc(input string n, input bit [2:0] m,
                       input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] ea,
                       input logic [WIDTH-1:0] ep);
        exp_t e;
        e.name = n;
        e.cb = m[2]; e.eb = eb;
        e.ca = m[1]; e.ea = ea;
        e.cp = m[0]; e.ep = ep;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    // Put a value on the bus through DIN and set A / opcode
    task automatic alu(input string n, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [2:0] op,
                       input logic [WIDTH-1:0] ea);
        clr();
        bus.A = a; bus.DIN = b; bus.din_out = 1'b1; bus.alu_op = op;
        cyc(n, M_BAP, b, ea, 16'h0000);
    endtask

    initial begin
        clr();
        Reset = 1'b1;
        @(posedge Clock);
        #1;

        // Reset state
        cyc("reset", M_BAP, 16'h0000, 16'h0000, 16'h0000);
        Reset = 1'b0;

        // Bus selection and priority
        clr(); bus.R3 = 16'h1234; bus.reg_out = 8'b0000_1000;
        cyc("bus_r3", M_BAP, 16'h1234, 16'h1234, 16'h0000);
        clr(); bus.R3 = 16'h1234; bus.reg_out = 8'b0000_1000; bus.DIN = 16'hBEEF; bus.din_out = 1'b1;
        cyc("bus_din_prio", M_B, 16'hBEEF, 16'h0, 16'h0);
        clr();
        cyc("bus_none", M_BA, 16'h0000, 16'h0000, 16'h0);
        clr(); bus.R1 = 16'h1111; bus.R3 = 16'h1234; bus.reg_out = 8'b0000_1010;
        cyc("bus_low_reg", M_B, 16'h1111, 16'h0, 16'h0);
        clr(); bus.G = 16'h5A5A; bus.g_out = 1'b1;
        cyc("bus_g", M_B, 16'h5A5A, 16'h0, 16'h0);
        clr(); bus.G = 16'h5A5A; bus.g_out = 1'b1; bus.R6 = 16'h6666; bus.reg_out = 8'b0100_0000;
        cyc("bus_reg_over_g", M_B, 16'h6666, 16'h0, 16'h0);

        // ALU
        alu("add",      16'h0005, 16'h0003, 3'b000, 16'h0008);
        alu("sub",      16'h0005, 16'h0003, 3'b001, 16'h0002);
        alu("sub_wrap", 16'h0003, 16'h0005, 3'b001, 16'hFFFE);
        alu("add_wrap", 16'hFFFF, 16'h0001, 3'b000, 16'h0000);
        alu("or",       16'h00F0, 16'h0F0F, 3'b010, 16'h0FFF);
        alu("slt_lt",   16'h0002, 16'h0007, 3'b011, 16'h0001);
        alu("slt_gt",   16'h0007, 16'h0002, 3'b011, 16'h0000);
        alu("slt_uns",  16'h8000, 16'h0001, 3'b011, 16'h0000);
        alu("sll",      16'h0001, 16'h0013, 3'b100, 16'h0008);
        alu("srl",      16'h8000, 16'h0004, 3'b101, 16'h0800);
        alu("op7",      16'h1234, 16'h5678, 3'b111, 16'h0000);
        alu("op6",      16'h1234, 16'h5678, 3'b110, 16'h0000);

        // PC increment, load, wrap
        clr(); bus.pc_en = 1'b1; bus.pc_incr = 1'b1;
        cyc("pc_inc0", M_P, 16'h0, 16'h0, 16'h0000);
        cyc("pc_inc1", M_P, 16'h0, 16'h0, 16'h0001);
        cyc("pc_inc2", M_P, 16'h0, 16'h0, 16'h0002);
        clr(); bus.pc_en = 1'b1; bus.pc_load = 1'b1; bus.DIN = 16'hFFFF; bus.din_out = 1'b1;
        cyc("pc_three", M_P, 16'h0, 16'h0, 16'h0003);
        clr(); bus.pc_en = 1'b1; bus.pc_incr = 1'b1;
        cyc("pc_ld_ffff", M_P, 16'h0, 16'h0, 16'hFFFF);
        clr(); bus.pc_en = 1'b1;
        cyc("pc_wrap", M_P, 16'h0, 16'h0, 16'h0000);

        // Load beats increment, enable gates, reset beats enable
        clr(); bus.pc_en = 1'b1; bus.pc_load = 1'b1; bus.pc_incr = 1'b1;
        bus.DIN = 16'h0040; bus.din_out = 1'b1;
        cyc("pc_en_idle", M_P, 16'h0, 16'h0, 16'h0000);
        clr(); bus.pc_incr = 1'b1;
        cyc("pc_ld_prio", M_P, 16'h0, 16'h0, 16'h0040);
        cyc("pc_hold", M_P, 16'h0, 16'h0, 16'h0040);
        Reset = 1'b1;
        cyc("pc_pre_rst", M_P, 16'h0, 16'h0, 16'h0040);
        Reset = 1'b0;
        clr();
        cyc("pc_rst_noen", M_P, 16'h0, 16'h0, 16'h0000);

        // PC driven onto the bus and reloaded from itself
        clr(); bus.pc_en = 1'b1; bus.pc_load = 1'b1; bus.DIN = 16'h0007; bus.din_out = 1'b1;
        cyc("pc_pre7", M_P, 16'h0, 16'h0, 16'h0000);
        clr(); bus.reg_out = 8'b1000_0000; bus.alu_op = 3'b000; bus.A = 16'h0001;
        bus.pc_en = 1'b1; bus.pc_load = 1'b1;
        cyc("pc_on_bus", M_BAP, 16'h0007, 16'h0008, 16'h0007);
        clr();
        cyc("pc_self_ld", M_P, 16'h0, 16'h0, 16'h0007);

        // Reset in the middle of counting
        clr(); bus.pc_en = 1'b1; bus.pc_incr = 1'b1;
        cyc("cnt_a", M_P, 16'h0, 16'h0, 16'h0007);
        Reset = 1'b1;
        cyc("cnt_b", M_P, 16'h0, 16'h0, 16'h0008);
        Reset = 1'b0;
        cyc("cnt_rst", M_P, 16'h0, 16'h0, 16'h0000);
        cyc("cnt_1", M_P, 16'h0, 16'h0, 16'h0001);
        clr();
        cyc("cnt_2", M_P, 16'h0, 16'h0, 16'h0002);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge Clock);
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
